// File: rtl/write_buffer.sv
// Packs a byte stream into 16-bit words (low byte first), queues them in a small FIFO and
// commits them to the memory controller over a CMD/ACK handshake, counting committed words.
module write_buffer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ROW_WIDTH  = 13
) (
   input  logic                 CLK_48MHZ,
   input  logic                 RESET,
   input  logic [7:0]           BYTE_IN,
   input  logic                 BYTE_VALID,
   input  logic                 FLUSH,
   input  logic                 WRITE_ACK,
   output logic                 WRITE_CMD,
   output logic [15:0]          DATA_WRITE,
   output logic [ROW_WIDTH-1:0] ROW_WRITE,
   output logic                 FULL,
   output logic                 OVERFLOW,
   output logic                 MEM_FULL
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0]      DepthCnt = CntW'(FIFO_DEPTH);
   localparam logic [ROW_WIDTH-1:0] RowMax   = '1;

   typedef enum logic {PkEmpty, PkHalf} pack_e;
   typedef enum logic {WrIdle, WrReq} wr_e;

   pack_e               pack_q, pack_d;
   wr_e                 wr_q, wr_d;
   logic [7:0]          lo_q, lo_d;
   logic [15:0]         mem_q [FIFO_DEPTH];
   logic [15:0]         mem_d [FIFO_DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic                full_q, full_d;
   logic                overflow_q, overflow_d;
   logic                cmd_q, cmd_d;
   logic [15:0]         data_q, data_d;
   logic [ROW_WIDTH-1:0] row_q, row_d;
   logic                mem_full_q, mem_full_d;
   logic                push, push_ok, pop;
   logic [15:0]         push_word;

   // Packer
   always_comb begin
      pack_d    = pack_q;
      lo_d      = lo_q;
      push      = 1'b0;
      push_word = 16'h0000;
      case (pack_q)
         PkEmpty: begin
            if (BYTE_VALID && FLUSH) begin
               push      = 1'b1;
               push_word = {8'h00, BYTE_IN};
            end else if (BYTE_VALID) begin
               lo_d   = BYTE_IN;
               pack_d = PkHalf;
            end
         end
         PkHalf: begin
            if (BYTE_VALID) begin
               push      = 1'b1;
               push_word = {BYTE_IN, lo_q};
               pack_d    = PkEmpty;
            end else if (FLUSH) begin
               push      = 1'b1;
               push_word = {8'h00, lo_q};
               pack_d    = PkEmpty;
            end
         end
         default: pack_d = PkEmpty;
      endcase
   end

   // Writer
   always_comb begin
      wr_d       = wr_q;
      cmd_d      = cmd_q;
      data_d     = data_q;
      row_d      = row_q;
      mem_full_d = mem_full_q;
      pop        = 1'b0;
      case (wr_q)
         WrIdle: begin
            if (count_q != '0 && !mem_full_q) begin
               data_d = mem_q[rd_ptr_q];
               cmd_d  = 1'b1;
               wr_d   = WrReq;
            end
         end
         WrReq: begin
            if (WRITE_ACK) begin
               cmd_d = 1'b0;
               pop   = 1'b1;
               wr_d  = WrIdle;
               if (row_q != RowMax) row_d = row_q + ROW_WIDTH'(1);
               if (row_d == RowMax) mem_full_d = 1'b1;
            end
         end
         default: wr_d = WrIdle;
      endcase
   end

   // FIFO: a pop in the same cycle frees the slot a push at full needs
   always_comb begin
      push_ok    = push && (count_q != DepthCnt || pop);
      overflow_d = overflow_q | (push && !push_ok);
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_word;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == DepthCnt);
   end

   always_ff @(posedge CLK_48MHZ or posedge RESET) begin
      if (RESET) begin
         pack_q     <= PkEmpty;
         wr_q       <= WrIdle;
         lo_q       <= 8'h00;
         mem_q      <= '{default: 16'h0000};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         cmd_q      <= 1'b0;
         data_q     <= 16'h0000;
         row_q      <= '0;
         mem_full_q <= 1'b0;
      end else begin
         pack_q     <= pack_d;
         wr_q       <= wr_d;
         lo_q       <= lo_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         cmd_q      <= cmd_d;
         data_q     <= data_d;
         row_q      <= row_d;
         mem_full_q <= mem_full_d;
      end
   end

   assign WRITE_CMD  = cmd_q;
   assign DATA_WRITE = data_q;
   assign ROW_WRITE  = row_q;
   assign FULL       = full_q;
   assign OVERFLOW   = overflow_q;
   assign MEM_FULL   = mem_full_q;

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: a transaction-level model (byte packer, word queue, request/ack writer)
// compared every cycle, plus directed scenarios with literal expectations.
module tb_write_buffer;

   localparam int unsigned Depth  = 4;
   localparam int unsigned RowW   = 3;
   localparam int unsigned RowMax = 7;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      byte_in = 8'h00;
   logic            byte_valid = 1'b0;
   logic            flush = 1'b0;
   logic            write_ack = 1'b0;
   logic            write_cmd;
   logic [15:0]     data_write;
   logic [RowW-1:0] row_write;
   logic            full, overflow, mem_full;

   always #5 clk = ~clk;

   write_buffer #(.FIFO_DEPTH(Depth), .ROW_WIDTH(RowW)) dut (
      .CLK_48MHZ (clk),
      .RESET     (rst),
      .BYTE_IN   (byte_in),
      .BYTE_VALID(byte_valid),
      .FLUSH     (flush),
      .WRITE_ACK (write_ack),
      .WRITE_CMD (write_cmd),
      .DATA_WRITE(data_write),
      .ROW_WRITE (row_write),
      .FULL      (full),
      .OVERFLOW  (overflow),
      .MEM_FULL  (mem_full)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state
   logic        m_half = 1'b0;
   logic [7:0]  m_lo = 8'h00;
   logic [15:0] m_q[$];
   logic        m_req = 1'b0;
   logic [15:0] m_data = 16'h0000;
   int          m_rows = 0;
   logic        m_ovf = 1'b0;
   logic        m_mf = 1'b0;
   logic        m_have;
   logic [15:0] m_w;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_half = 1'b0; m_lo = 8'h00; m_q.delete(); m_req = 1'b0; m_data = 16'h0000;
         m_rows = 0; m_ovf = 1'b0; m_mf = 1'b0;
      end else begin
         m_have = 1'b0;
         m_w    = 16'h0000;
         if (byte_valid) begin
            if (m_half) begin
               m_w = {byte_in, m_lo}; m_have = 1'b1; m_half = 1'b0;
            end else if (flush) begin
               m_w = {8'h00, byte_in}; m_have = 1'b1;
            end else begin
               m_lo = byte_in; m_half = 1'b1;
            end
         end else if (flush && m_half) begin
            m_w = {8'h00, m_lo}; m_have = 1'b1; m_half = 1'b0;
         end
         // writer sees the queue as it stood before this edge's push
         if (m_req) begin
            if (write_ack) begin
               void'(m_q.pop_front());
               m_req = 1'b0;
               if (m_rows < RowMax) m_rows++;
               if (m_rows == RowMax) m_mf = 1'b1;
            end
         end else if (m_q.size() > 0 && !m_mf) begin
            m_req  = 1'b1;
            m_data = m_q[0];
         end
         if (m_have) begin
            if (m_q.size() < Depth) m_q.push_back(m_w);
            else m_ovf = 1'b1;
         end
      end
   end

   // Memory-controller responder: ack after WRITE_CMD has been seen for one cycle
   logic        ack_en = 1'b0;
   logic        cmd_prev = 1'b0;
   logic [15:0] obs[$];
   int          cmd_cycles = 0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         cmd_prev  = 1'b0;
         write_ack = 1'b0;
      end else begin
         write_ack = ack_en && write_cmd && cmd_prev;
         cmd_prev  = write_cmd;
         if (write_cmd) cmd_cycles++;
         if (write_cmd && write_ack) obs.push_back(data_write);
      end
   end

   logic chk_en = 1'b0;

   initial forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
         check("model WRITE_CMD", {31'd0, write_cmd}, {31'd0, m_req});
         check("model DATA_WRITE", {16'd0, data_write}, {16'd0, m_data});
         check("model ROW_WRITE", {29'd0, row_write}, m_rows);
         check("model FULL", {31'd0, full}, {31'd0, (m_q.size() == Depth)});
         check("model OVERFLOW", {31'd0, overflow}, {31'd0, m_ovf});
         check("model MEM_FULL", {31'd0, mem_full}, {31'd0, m_mf});
      end
   end

   // Caller is at a negedge; drive for one cycle
   task automatic step(input logic bv, input logic [7:0] b, input logic fl);
      byte_valid = bv;
      byte_in    = b;
      flush      = fl;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      ack_en = 1'b0;
      rst    = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      obs.delete();
      cmd_cycles = 0;
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " WRITE_CMD"}, {31'd0, write_cmd}, 32'd0);
      check({tag, " DATA_WRITE"}, {16'd0, data_write}, 32'h0000);
      check({tag, " ROW_WRITE"}, {29'd0, row_write}, 32'd0);
      check({tag, " FULL"}, {31'd0, full}, 32'd0);
      check({tag, " OVERFLOW"}, {31'd0, overflow}, 32'd0);
      check({tag, " MEM_FULL"}, {31'd0, mem_full}, 32'd0);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst    = 1'b0;
      chk_en = 1'b1;

      // 1: simple pair
      ack_en = 1'b1;
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      idle(8);
      check("t1 writes", obs.size(), 1);
      check("t1 word", {16'd0, obs[0]}, 32'h2211);
      check("t1 cmd cycles", cmd_cycles, 2);
      check("t1 ROW_WRITE", {29'd0, row_write}, 1);

      // 2: flush a half word, then flush while empty
      do_reset();
      ack_en = 1'b1;
      step(1'b1, 8'hA5, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      idle(8);
      check("t2 writes", obs.size(), 1);
      check("t2 word", {16'd0, obs[0]}, 32'h00A5);
      check("t2 ROW_WRITE", {29'd0, row_write}, 1);
      step(1'b0, 8'h00, 1'b1);
      idle(8);
      check("t2 empty flush writes", obs.size(), 1);
      check("t2 empty flush cmd cycles", cmd_cycles, 2);

      // 3: fill with ack held off, then drain
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
      idle(4);
      check("t3 FULL", {31'd0, full}, 1);
      check("t3 OVERFLOW", {31'd0, overflow}, 1);
      check("t3 ROW_WRITE before ack", {29'd0, row_write}, 0);
      ack_en = 1'b1;
      idle(20);
      check("t3 writes", obs.size(), 4);
      check("t3 word0", {16'd0, obs[0]}, 32'h0100);
      check("t3 word1", {16'd0, obs[1]}, 32'h0302);
      check("t3 word2", {16'd0, obs[2]}, 32'h0504);
      check("t3 word3", {16'd0, obs[3]}, 32'h0706);
      check("t3 ROW_WRITE", {29'd0, row_write}, 4);
      check("t3 FULL after drain", {31'd0, full}, 0);

      // 4: ROW_WRITE saturation at 7
      do_reset();
      ack_en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 8'(2 * k), 1'b0);
         step(1'b1, 8'(2 * k + 1), 1'b0);
         idle(4);
      end
      check("t4 ROW_WRITE", {29'd0, row_write}, 7);
      check("t4 MEM_FULL", {31'd0, mem_full}, 1);
      check("t4 writes", obs.size(), 7);
      check("t4 last word", {16'd0, obs[6]}, 32'h0D0C);
      check("t4 OVERFLOW early", {31'd0, overflow}, 0);
      for (int k = 0; k < 6; k++) step(1'b1, 8'(8'h40 + k), 1'b0);
      idle(6);
      check("t4 OVERFLOW late", {31'd0, overflow}, 1);
      check("t4 FULL", {31'd0, full}, 1);
      check("t4 writes after", obs.size(), 7);
      check("t4 ROW_WRITE after", {29'd0, row_write}, 7);

      // 5: reset in the middle of a request
      do_reset();
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      step(1'b1, 8'h03, 1'b0);
      step(1'b1, 8'h04, 1'b0);
      idle(2);
      check("t5 WRITE_CMD pending", {31'd0, write_cmd}, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("t5 async reset");
      @(negedge clk);
      obs.delete();
      cmd_cycles = 0;
      rst    = 1'b0;
      ack_en = 1'b1;
      step(1'b1, 8'h33, 1'b0);
      step(1'b1, 8'h44, 1'b0);
      idle(8);
      check("t5 writes", obs.size(), 1);
      check("t5 word", {16'd0, obs[0]}, 32'h4433);
      check("t5 ROW_WRITE", {29'd0, row_write}, 1);

      // 6: byte and flush together while empty
      do_reset();
      ack_en = 1'b1;
      step(1'b1, 8'h5C, 1'b1);
      idle(8);
      check("t6 writes", obs.size(), 1);
      check("t6 word", {16'd0, obs[0]}, 32'h005C);
      check("t6 ROW_WRITE", {29'd0, row_write}, 1);
      check("t6 cmd cycles", cmd_cycles, 2);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
